// File: rtl/hdr_engine_pkg.sv
// Shared header-engine definitions: lookup key layout and IP protocol numbers.
// Imported by the lookup scheduler, its arbiter and the bench.
package hdr_engine_pkg;

   localparam int KEY_W     = 72;
   localparam int PROTO_MSB = 71;
   localparam int PROTO_LSB = 64;
   localparam int SA_MSB    = 63;
   localparam int SA_LSB    = 32;
   localparam int DA_MSB    = 31;
   localparam int DA_LSB    = 0;

   localparam logic [7:0] IPPROTO_ICMP = 8'd1;
   localparam logic [7:0] IPPROTO_TCP  = 8'd6;
   localparam logic [7:0] IPPROTO_UDP  = 8'd17;

   typedef logic [KEY_W-1:0] key_t;

   // Field view of a key; the declaration order matches {proto, SA, DA}.
   typedef struct packed {
      logic [7:0]  proto;
      logic [31:0] sa;
      logic [31:0] da;
   } key_fields_t;

   function automatic logic [7:0] key_proto(input key_t k);
      return k[PROTO_MSB:PROTO_LSB];
   endfunction

endpackage

// File: rtl/hdr_lookup_sched_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr, wrapping.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter
   import hdr_engine_pkg::*;
#(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic          en,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          any
);

   logic [IW-1:0] idx;

   // NOTE: every variable written here gets a default first, so no path leaves
   // a value unassigned and no latch is inferred.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = '0;
      for (int k = 0; k < N; k++) begin
         if (int'(ptr) + k >= N) idx = IW'(int'(ptr) + k - N);
         else                    idx = IW'(int'(ptr) + k);
         if (en && !any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = idx;
         end
      end
   end

endmodule

// File: rtl/hdr_lookup_sched.sv
// Shares one combinational TCAM stage between NUM_REQ header parsers: round-robin
// grant, registered key toward the TCAM, registered result with id/tag, and statistics.
module hdr_lookup_sched
   import hdr_engine_pkg::*;
#(
   parameter  int NUM_REQ = 4,
   parameter  int BVSIZE  = 256,
   parameter  int TAG_W   = 8,
   parameter  int CNT_W   = 32,
   localparam int ID_W    = $clog2(NUM_REQ)
) (
   input  logic                     axi_aclk,
   input  logic                     axi_resetn,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*KEY_W-1:0] req_key,
   input  logic [NUM_REQ*TAG_W-1:0] req_tag,
   output logic [KEY_W-1:0]         lut_key,
   input  logic [BVSIZE-1:0]        lut_bv,
   output logic                     res_valid,
   input  logic                     res_ready,
   output logic [BVSIZE-1:0]        res_bv,
   output logic [ID_W-1:0]          res_id,
   output logic [TAG_W-1:0]         res_tag,
   output logic                     res_hit,
   input  logic                     stat_clear,
   output logic [CNT_W-1:0]         stat_lookups,
   output logic [CNT_W-1:0]         stat_hits
);

   logic               adv1, adv2, fire;
   logic               any_gnt;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx, rr_ptr, rr_next;
   key_t               sel_key;
   logic [TAG_W-1:0]   sel_tag;

   key_t               s1_key;
   logic [ID_W-1:0]    s1_id;
   logic [TAG_W-1:0]   s1_tag;
   logic               v1;
   logic [BVSIZE-1:0]  s2_bv;
   logic [ID_W-1:0]    s2_id;
   logic [TAG_W-1:0]   s2_tag;
   logic               v2;

   assign adv2 = ~v2 | res_ready;
   assign adv1 = ~v1 | adv2;
   assign fire = v2 & res_ready;

   // Gating with the reset keeps req_ready low while held in reset.
   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req     (req_valid),
      .en      (adv1 & axi_resetn),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx),
      .any     (any_gnt)
   );

   assign req_ready = gnt;
   assign rr_next   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

   // One-hot AND-OR select keeps the key path off the grant logic.
   always_comb begin
      sel_key = '0;
      sel_tag = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_key = sel_key | ({KEY_W{gnt[i]}} & req_key[KEY_W*i +: KEY_W]);
         sel_tag = sel_tag | ({TAG_W{gnt[i]}} & req_tag[TAG_W*i +: TAG_W]);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others, independent of statement order.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         rr_ptr <= '0;
         v1     <= 1'b0;
         s1_key <= '0;
         s1_id  <= '0;
         s1_tag <= '0;
      end else if (adv1) begin
         v1 <= any_gnt;
         if (any_gnt) begin
            rr_ptr <= rr_next;
            s1_key <= sel_key;
            s1_id  <= gnt_idx;
            s1_tag <= sel_tag;
         end
      end
   end

   // S2 captures the TCAM answer for the key S1 has been presenting this cycle.
   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         v2     <= 1'b0;
         s2_bv  <= '0;
         s2_id  <= '0;
         s2_tag <= '0;
      end else if (adv2) begin
         v2     <= v1;
         s2_bv  <= lut_bv;
         s2_id  <= s1_id;
         s2_tag <= s1_tag;
      end
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else if (stat_clear) begin
         stat_lookups <= '0;
         stat_hits    <= '0;
      end else if (fire) begin
         stat_lookups <= stat_lookups + CNT_W'(1);
         if (res_hit) stat_hits <= stat_hits + CNT_W'(1);
      end
   end

   assign lut_key   = s1_key;
   assign res_valid = v2;
   assign res_bv    = s2_bv;
   assign res_id    = s2_id;
   assign res_tag   = s2_tag;
   assign res_hit   = |s2_bv;

endmodule

// File: tb/tb_hdr_lookup_sched.sv
// Self-checking bench for hdr_lookup_sched: randomized requesters and a TCAM model,
// checked against an in-order scoreboard of a 2-deep lookup pipeline.
module tb_hdr_lookup_sched;
   import hdr_engine_pkg::*;

   localparam int NR = 4;
   localparam int BV = 256;
   localparam int TW = 8;
   localparam int CW = 32;
   localparam int IW = 2;

   logic                axi_aclk;
   logic                axi_resetn;
   logic [NR-1:0]       req_valid;
   logic [NR-1:0]       req_ready;
   logic [NR*KEY_W-1:0] req_key;
   logic [NR*TW-1:0]    req_tag;
   logic [KEY_W-1:0]    lut_key;
   logic [BV-1:0]       lut_bv;
   logic                res_valid;
   logic                res_ready;
   logic [BV-1:0]       res_bv;
   logic [IW-1:0]       res_id;
   logic [TW-1:0]       res_tag;
   logic                res_hit;
   logic                stat_clear;
   logic [CW-1:0]       stat_lookups;
   logic [CW-1:0]       stat_hits;

   hdr_lookup_sched #(.NUM_REQ(NR), .BVSIZE(BV), .TAG_W(TW), .CNT_W(CW)) dut (
      .axi_aclk     (axi_aclk),
      .axi_resetn   (axi_resetn),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_key      (req_key),
      .req_tag      (req_tag),
      .lut_key      (lut_key),
      .lut_bv       (lut_bv),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_bv       (res_bv),
      .res_id       (res_id),
      .res_tag      (res_tag),
      .res_hit      (res_hit),
      .stat_clear   (stat_clear),
      .stat_lookups (stat_lookups),
      .stat_hits    (stat_hits)
   );

   initial axi_aclk = 1'b0;
   always #5 axi_aclk = ~axi_aclk;

   // Rule set of the TCAM model: protocol rules, a DA /8 rule family, an SA /8 rule family.
   function automatic logic [BV-1:0] tcam_model(input logic [KEY_W-1:0] k);
      logic [BV-1:0] bv;
      bv = '0;
      if (k[PROTO_MSB:PROTO_LSB] == IPPROTO_TCP)  bv[2] = 1'b1;
      if (k[PROTO_MSB:PROTO_LSB] == IPPROTO_UDP)  bv[5] = 1'b1;
      if (k[PROTO_MSB:PROTO_LSB] == IPPROTO_ICMP) bv[9] = 1'b1;
      if (k[DA_MSB -: 8] == 8'h0a) bv[64 + int'(k[5:0])] = 1'b1;
      if (k[SA_MSB -: 8] == 8'hc0) bv[200 + int'(k[35:32])] = 1'b1;
      return bv;
   endfunction

   assign lut_bv = tcam_model(lut_key);

   typedef struct {
      logic [IW-1:0]    id;
      logic [TW-1:0]    tag;
      logic [BV-1:0]    bv;
      logic [KEY_W-1:0] key;
      int               acc;
   } item_t;

   item_t         exp_q[$];
   int            dlv_id[$];
   int            dlv_cyc[$];
   int            n_checks, n_errors;
   int            cyc, m_ptr, src_mode, last_grant;
   logic [CW-1:0] m_lookups, m_hits;
   logic          obs_valid, obs_hit;
   logic [NR-1:0] obs_rdy;
   logic [IW-1:0] obs_id;
   logic [TW-1:0] obs_tag;
   logic [BV-1:0] obs_bv;

   task automatic check(input string tag, input logic [BV-1:0] got, input logic [BV-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [KEY_W-1:0] rand_key();
      key_fields_t f;
      case ($urandom_range(4))
         0:       f.proto = IPPROTO_TCP;
         1:       f.proto = IPPROTO_UDP;
         2:       f.proto = IPPROTO_ICMP;
         3:       f.proto = 8'h2F;
         default: f.proto = 8'($urandom);
      endcase
      f.sa = $urandom;
      f.da = $urandom;
      if ($urandom_range(1) == 0) f.sa[31:24] = 8'hc0;
      if ($urandom_range(1) == 0) f.da[31:24] = 8'h0a;
      return f;
   endfunction

   task automatic set_req(input int i, input logic [KEY_W-1:0] k, input logic [TW-1:0] t);
      req_valid[i]           = 1'b1;
      req_key[KEY_W*i +: KEY_W] = k;
      req_tag[TW*i +: TW]    = t;
   endtask

   // One clock: sample at negedge, check against the scoreboard, advance the model,
   // then update requesters just after the rising edge.
   task automatic cycle();
      logic [NR-1:0] exp_rdy;
      logic          exp_v;
      int            g, gi;
      item_t         it;
      @(negedge axi_aclk);
      check("stat_lookups", stat_lookups, m_lookups);
      check("stat_hits", stat_hits, m_hits);
      exp_rdy = '0;
      g = -1;
      if (exp_q.size() < 2 || res_ready) begin
         for (int k = 0; k < NR; k++) begin
            gi = (m_ptr + k) % NR;
            if (g < 0 && req_valid[gi]) begin
               g = gi;
               exp_rdy[gi] = 1'b1;
            end
         end
      end
      check("req_ready", req_ready, exp_rdy);
      exp_v = exp_q.size() > 0 && (cyc - exp_q[0].acc >= 2);
      check("res_valid", res_valid, exp_v);
      if (exp_v) begin
         check("res_id", res_id, exp_q[0].id);
         check("res_tag", res_tag, exp_q[0].tag);
         check("res_bv", res_bv, exp_q[0].bv);
         check("res_hit", res_hit, |exp_q[0].bv);
      end
      if (exp_q.size() == 2 && !res_ready) check("lut_key_stall", lut_key, exp_q[1].key);
      obs_valid = res_valid;
      obs_id    = res_id;
      obs_tag   = res_tag;
      obs_bv    = res_bv;
      obs_hit   = res_hit;
      obs_rdy   = req_ready;
      if (exp_v && res_ready) begin
         it = exp_q.pop_front();
         dlv_id.push_back(int'(it.id));
         dlv_cyc.push_back(cyc);
         m_lookups = m_lookups + 1;
         if (|it.bv) m_hits = m_hits + 1;
      end
      if (stat_clear) begin
         m_lookups = '0;
         m_hits    = '0;
      end
      last_grant = g;
      if (g >= 0) begin
         it.id  = IW'(g);
         it.tag = req_tag[TW*g +: TW];
         it.key = req_key[KEY_W*g +: KEY_W];
         it.bv  = tcam_model(it.key);
         it.acc = cyc;
         exp_q.push_back(it);
         m_ptr = (g + 1) % NR;
      end
      @(posedge axi_aclk);
      #1;
      cyc++;
      if (g >= 0) begin
         if (src_mode == 1) set_req(g, rand_key(), TW'($urandom));
         else               req_valid[g] = 1'b0;
      end
      if (src_mode == 2) begin
         for (int i = 0; i < NR; i++)
            if (!req_valid[i] && $urandom_range(2) == 0) set_req(i, rand_key(), TW'($urandom));
         res_ready  = ($urandom_range(3) != 0);
         stat_clear = ($urandom_range(63) == 0);
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while ((req_valid != '0 || exp_q.size() != 0) && n < 100) begin
         cycle();
         n++;
      end
      check(tag, (req_valid == '0 && exp_q.size() == 0), 1'b1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_res_valid"}, res_valid, 1'b0);
      check({tag, "_lut_key"}, lut_key, '0);
      check({tag, "_req_ready"}, req_ready, '0);
      check({tag, "_res_bv"}, res_bv, '0);
      check({tag, "_res_idtag"}, {res_id, res_tag, res_hit}, '0);
      check({tag, "_stats"}, {stat_lookups, stat_hits}, '0);
   endtask

   initial begin
      logic [CW-1:0] base_l, base_h;
      n_checks = 0; n_errors = 0; cyc = 0; m_ptr = 0; src_mode = 0; last_grant = -1;
      m_lookups = '0; m_hits = '0;
      axi_resetn = 1'b0;
      req_valid = '0; req_key = '0; req_tag = '0;
      res_ready = 1'b1; stat_clear = 1'b0;

      // Reset state, then idle after release
      repeat (3) @(posedge axi_aclk);
      #1;
      check_reset_outputs("t1_rst");
      axi_resetn = 1'b1;
      repeat (3) cycle();
      check("t1_idle_valid", obs_valid, 1'b0);
      check("t1_idle_ready", obs_rdy, '0);
      check("t1_idle_lut_key", lut_key, '0);

      // Single TCP request from req1: result exactly two cycles after accept
      set_req(1, 72'h06_ac1c0b05_0a000001, 8'h5A);
      cycle();
      check("t2_accept", obs_rdy, 4'b0010);
      cycle();
      check("t2_not_yet", obs_valid, 1'b0);
      cycle();
      check("t2_valid", obs_valid, 1'b1);
      check("t2_id", obs_id, 2'd1);
      check("t2_tag", obs_tag, 8'h5A);
      check("t2_bv2", obs_bv[2], 1'b1);
      check("t2_hit", obs_hit, 1'b1);
      cycle();
      check("t2_lookups", stat_lookups, 32'd1);
      check("t2_hits", stat_hits, 32'd1);

      // All requesters busy: strict rotation, one result per cycle
      src_mode = 1;
      for (int i = 0; i < NR; i++) set_req(i, rand_key(), TW'($urandom));
      dlv_id.delete(); dlv_cyc.delete();
      for (int n = 0; n < 40 && dlv_id.size() < 16; n++) cycle();
      check("t3_count", dlv_id.size() >= 16, 1'b1);
      if (dlv_id.size() > 0) check("t3_first", dlv_id[0], 2);
      for (int k = 0; k < 15 && k + 1 < dlv_id.size(); k++) begin
         check("t3_order", dlv_id[k+1], (dlv_id[k] + 1) % NR);
         check("t3_gap", dlv_cyc[k+1] - dlv_cyc[k], 1);
      end

      // Backpressure with a full pipe
      res_ready = 1'b0;
      repeat (5) begin
         cycle();
         check("t4_ready_low", obs_rdy, '0);
      end
      res_ready = 1'b1;
      dlv_id.delete(); dlv_cyc.delete();
      repeat (8) cycle();
      check("t4_resume", dlv_id.size(), 8);

      // No-match lookup counts as a lookup but not a hit
      src_mode = 0;
      drain("t5_drain");
      base_l = m_lookups;
      base_h = m_hits;
      set_req(3, 72'h2F_01020304_05060708, 8'h33);
      repeat (3) cycle();
      check("t5_valid", obs_valid, 1'b1);
      check("t5_id", obs_id, 2'd3);
      check("t5_bv", obs_bv, '0);
      check("t5_hit", obs_hit, 1'b0);
      cycle();
      check("t5_lookups", stat_lookups, base_l + 1);
      check("t5_hits", stat_hits, base_h);

      // Randomized traffic, backpressure and statistic clears
      src_mode = 2;
      repeat (1500) cycle();
      src_mode = 0;
      res_ready = 1'b1;
      stat_clear = 1'b0;
      drain("rand_drain");

      // Reset with both stages occupied
      src_mode = 1;
      for (int i = 0; i < NR; i++) set_req(i, rand_key(), TW'($urandom));
      res_ready = 1'b0;
      repeat (4) cycle();
      check("t6_full", exp_q.size(), 2);
      axi_resetn = 1'b0;
      #1;
      check_reset_outputs("t6_rst");
      exp_q.delete();
      m_ptr = 0;
      m_lookups = '0;
      m_hits = '0;
      repeat (2) @(posedge axi_aclk);
      #1;
      axi_resetn = 1'b1;
      res_ready = 1'b1;
      cycle();
      check("t6_grant0", last_grant, 0);
      src_mode = 0;
      drain("final_drain");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
